// File: rtl/score_digit_renderer.sv
// Two-digit score sprite renderer: binary score to BCD by repeated subtraction,
// committed at frame start, drawn from a 20x20 digit ROM through a 2-stage pixel pipeline.
module score_digit_renderer #(
  parameter int          X0     = 600,
  parameter int          Y0     = 20,
  parameter int          GAP    = 4,
  parameter logic [7:0]  TRANSP = 8'h00
) (
  input  logic       i_clk2,
  input  logic       i_rst_n,
  input  logic [9:0] i_pix_x,
  input  logic [9:0] i_pix_y,
  input  logic       i_video_on,
  input  logic       i_frame_start,
  input  logic [6:0] i_score,
  input  logic       i_score_load,
  input  logic [7:0] i_numberdata,
  output logic [9:0] o_numberaddr,
  output logic [3:0] o_digit_sel,
  output logic [7:0] o_pixel,
  output logic       o_pixel_valid,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  localparam logic [10:0] TENS_L = 11'(X0);
  localparam logic [10:0] TENS_R = 11'(X0 + 20);
  localparam logic [10:0] ONES_L = 11'(X0 + 20 + GAP);
  localparam logic [10:0] ONES_R = 11'(X0 + 40 + GAP);
  localparam logic [10:0] BOX_T  = 11'(Y0);
  localparam logic [10:0] BOX_B  = 11'(Y0 + 20);

  state_t     state_q;
  logic [6:0] rem_q;
  logic [3:0] tens_q;
  logic [3:0] pend_tens_q, pend_ones_q;
  logic [3:0] disp_tens_q, disp_ones_q;
  logic       busy_q;

  logic [9:0] addr_q, addr_d;
  logic [3:0] sel_q, sel_d;
  logic       hit1_q, hit1_d;
  logic       hit2_q;
  logic [7:0] pixel_q;
  logic       pixel_valid_q;

  logic [10:0] x_ext, y_ext;
  logic        in_rows, in_tens, in_ones;
  logic [9:0]  dy, dx_tens, dx_ones;

  // Extend by one bit so box edges near the top of the 10-bit range cannot wrap.
  assign x_ext   = {1'b0, i_pix_x};
  assign y_ext   = {1'b0, i_pix_y};
  assign in_rows = (y_ext >= BOX_T) && (y_ext < BOX_B);
  assign in_tens = in_rows && (x_ext >= TENS_L) && (x_ext < TENS_R);
  assign in_ones = in_rows && (x_ext >= ONES_L) && (x_ext < ONES_R);
  assign dy      = i_pix_y - 10'(Y0);
  assign dx_tens = i_pix_x - 10'(X0);
  assign dx_ones = i_pix_x - 10'(X0 + 20 + GAP);

  always_comb begin
    addr_d = 10'd0;
    sel_d  = 4'd0;
    hit1_d = 1'b0;
    if (i_video_on && in_tens) begin
      addr_d = (dy * 10'd20) + dx_tens;
      sel_d  = disp_tens_q;
      hit1_d = 1'b1;
    end else if (i_video_on && in_ones) begin
      addr_d = (dy * 10'd20) + dx_ones;
      sel_d  = disp_ones_q;
      hit1_d = 1'b1;
    end
  end

  // Pixel pipeline: address at E0, ROM read at E1, pixel registered at E2.
  always_ff @(posedge i_clk2) begin
    if (!i_rst_n) begin
      addr_q        <= 10'd0;
      sel_q         <= 4'd0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      pixel_q       <= 8'd0;
      pixel_valid_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
      hit1_q <= hit1_d;
      hit2_q <= hit1_q;
      if (hit2_q && (i_numberdata != TRANSP)) begin
        pixel_q       <= i_numberdata;
        pixel_valid_q <= 1'b1;
      end else begin
        pixel_q       <= 8'd0;
        pixel_valid_q <= 1'b0;
      end
    end
  end

  // Displayed digits only change on a frame boundary, so a frame never mixes scores.
  always_ff @(posedge i_clk2) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rem_q       <= 7'd0;
      tens_q      <= 4'd0;
      pend_tens_q <= 4'd0;
      pend_ones_q <= 4'd0;
      disp_tens_q <= 4'd0;
      disp_ones_q <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_score_load) begin
            rem_q   <= (i_score > 7'd99) ? 7'd99 : i_score;
            tens_q  <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          if (rem_q >= 7'd10) begin
            rem_q  <= rem_q - 7'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            pend_tens_q <= tens_q;
            pend_ones_q <= rem_q[3:0];
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (i_frame_start) begin
            disp_tens_q <= pend_tens_q;
            disp_ones_q <= pend_ones_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_numberaddr  = addr_q;
  assign o_digit_sel   = sel_q;
  assign o_pixel       = pixel_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer: pixel addressing, pipeline latency,
// BCD conversion timing, commit at frame start, transparency and reset.
module tb_score_digit_renderer;

  logic       clk2 = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_on, frame_start, score_load;
  logic [6:0] score;
  logic [7:0] rom_q;
  logic [9:0] numberaddr;
  logic [3:0] digit_sel;
  logic [7:0] pixel;
  logic       pixel_valid, busy;
  logic       transp_mode;

  int total = 0;
  int bad   = 0;

  score_digit_renderer dut (
    .i_clk2        (clk2),
    .i_rst_n       (rst_n),
    .i_pix_x       (pix_x),
    .i_pix_y       (pix_y),
    .i_video_on    (video_on),
    .i_frame_start (frame_start),
    .i_score       (score),
    .i_score_load  (score_load),
    .i_numberdata  (rom_q),
    .o_numberaddr  (numberaddr),
    .o_digit_sel   (digit_sel),
    .o_pixel       (pixel),
    .o_pixel_valid (pixel_valid),
    .o_busy        (busy)
  );

  always #5 clk2 = ~clk2;

  // Synchronous ROM model: never returns 0 unless transparency is forced.
  always @(posedge clk2)
    rom_q <= transp_mode ? 8'h00 : (8'h80 | {1'b0, digit_sel[2:0], numberaddr[3:0]});

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel sampled at E0: address/digit checked after E0, pixel after E2.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [9:0] e_addr, input logic [3:0] e_sel,
                       input logic [7:0] e_pix, input logic e_valid);
    pix_x = x; pix_y = y; video_on = 1'b1;
    step();
    check({tag, "_addr"}, 32'(numberaddr), 32'(e_addr));
    check({tag, "_sel"}, 32'(digit_sel), 32'(e_sel));
    video_on = 1'b0;
    step();
    step();
    check({tag, "_pix"}, 32'(pixel), 32'(e_pix));
    check({tag, "_valid"}, 32'(pixel_valid), 32'(e_valid));
    $display("probe %s x=%0d y=%0d addr=%0d sel=%0d pix=%0h valid=%0b",
             tag, x, y, numberaddr, digit_sel, pixel, pixel_valid);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pix_x = 10'd0; pix_y = 10'd0; video_on = 1'b0;
    frame_start = 1'b0; score = 7'd0; score_load = 1'b0; transp_mode = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(numberaddr), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_pix", 32'(pixel), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    $display("reset busy=%0b addr=%0d pix=%0h", busy, numberaddr, pixel);
    rst_n = 1'b1;

    // Inside tens box, then immediately outside: valid goes high at E2, low at E3.
    pix_x = 10'd605; pix_y = 10'd23; video_on = 1'b1;
    step();
    check("e0_addr", 32'(numberaddr), 32'd65);
    check("e0_sel", 32'(digit_sel), 32'd0);
    pix_x = 10'd599;
    step();
    check("e1_addr_outside", 32'(numberaddr), 32'd0);
    check("e1_valid", 32'(pixel_valid), 32'd0);
    video_on = 1'b0;
    step();
    check("e2_pix", 32'(pixel), 32'h81);
    check("e2_valid", 32'(pixel_valid), 32'd1);
    step();
    check("e3_outside_valid", 32'(pixel_valid), 32'd0);
    check("e3_outside_pix", 32'(pixel), 32'd0);
    $display("pipeline latency sequence done");

    // Load 47: 4 subtracts + 1 store, frame_start held so commit is the first HOLD edge.
    score = 7'd47; score_load = 1'b1;
    step();
    check("l47_busy_load", 32'(busy), 32'd1);
    score_load = 1'b0;
    frame_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin score = 7'd20; score_load = 1'b1; end
      else score_load = 1'b0;
      step();
      check($sformatf("l47_busy_c%0d", i), 32'(busy), 32'd1);
    end
    score_load = 1'b0;
    step();
    check("l47_busy_commit", 32'(busy), 32'd0);
    frame_start = 1'b0;
    $display("load 47 committed busy=%0b", busy);
    probe("d47_tens", 10'd605, 10'd23, 10'd65, 4'd4, 8'hC1, 1'b1);
    probe("d47_ones", 10'd630, 10'd23, 10'd66, 4'd7, 8'hF2, 1'b1);

    // Load 120 clamps to 99; displayed digits must not change before the commit.
    score = 7'd120; score_load = 1'b1;
    step();
    score_load = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("l120_busy_hold", 32'(busy), 32'd1);
    probe("d120_pre", 10'd630, 10'd23, 10'd66, 4'd7, 8'hF2, 1'b1);
    frame_pulse();
    check("l120_busy_commit", 32'(busy), 32'd0);
    probe("d99_tens", 10'd605, 10'd23, 10'd65, 4'd9, 8'h91, 1'b1);
    probe("d99_ones", 10'd630, 10'd23, 10'd66, 4'd9, 8'h92, 1'b1);

    // Load 5: a single CONV cycle stores, next edge commits.
    score = 7'd5; score_load = 1'b1;
    step();
    score_load = 1'b0;
    frame_start = 1'b1;
    step();
    check("l5_busy_c1", 32'(busy), 32'd1);
    step();
    check("l5_busy_commit", 32'(busy), 32'd0);
    frame_start = 1'b0;
    probe("d05_tens", 10'd605, 10'd23, 10'd65, 4'd0, 8'h81, 1'b1);
    probe("d05_ones", 10'd630, 10'd23, 10'd66, 4'd5, 8'hD2, 1'b1);

    // Transparent ROM value inside a box.
    transp_mode = 1'b1;
    probe("transp", 10'd630, 10'd23, 10'd66, 4'd5, 8'h00, 1'b0);
    transp_mode = 1'b0;

    // Reset while holding a pending 47.
    score = 7'd47; score_load = 1'b1;
    step();
    score_load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("hold47_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; pix_x = 10'd630; pix_y = 10'd23; video_on = 1'b1;
    step();
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_addr", 32'(numberaddr), 32'd0);
    check("rst2_sel", 32'(digit_sel), 32'd0);
    check("rst2_pix", 32'(pixel), 32'd0);
    check("rst2_valid", 32'(pixel_valid), 32'd0);
    rst_n = 1'b1; video_on = 1'b0;
    step();
    frame_pulse();
    check("rst2_busy_after_frame", 32'(busy), 32'd0);
    probe("rst2_tens", 10'd605, 10'd23, 10'd65, 4'd0, 8'h81, 1'b1);
    probe("rst2_ones", 10'd630, 10'd23, 10'd66, 4'd0, 8'h82, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_digit_renderer.md
SCORE_DIGIT_RENDERER -- requirements
Module: score_digit_renderer

Interface
REQ-001 SHALL have parameter X0, default 600, x of tens-digit left edge.
REQ-002 SHALL have parameter Y0, default 20, y of both digits' top edge.
REQ-003 SHALL have parameter GAP, default 4, pixels between tens and ones digit.
REQ-004 SHALL have parameter TRANSP, default 8'h00, ROM value treated as transparent.
REQ-005 SHALL have port i_clk2  in  1  the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports i_pix_x, i_pix_y  in  10 each  current scan coordinate.
REQ-008 SHALL have port i_video_on  in  1  active display area.
REQ-009 SHALL have port i_frame_start  in  1  one-cycle pulse at start of frame.
REQ-010 SHALL have port i_score  in  7  binary score.
REQ-011 SHALL have port i_score_load  in  1  one-cycle request to convert i_score.
REQ-012 SHALL have port i_numberdata  in  8  digit-ROM pixel, valid one cycle after address.
REQ-013 SHALL have port o_numberaddr  out  10  digit-ROM address, 0..399.
REQ-014 SHALL have port o_digit_sel  out  4  digit value 0..9 selecting the ROM image.
REQ-015 SHALL have port o_pixel  out  8  sprite pixel.
REQ-016 SHALL have port o_pixel_valid  out  1  o_pixel is opaque and must overlay background.
REQ-017 SHALL have port o_busy  out  1  conversion in progress.

Function
REQ-018 SHALL implement digit sprites 20x20; tens box x in [X0, X0+20), ones box x in [X0+20+GAP, X0+40+GAP), both y in [Y0, Y0+20).
REQ-019 SHALL, at each edge with i_video_on=1 and coordinate inside a box, register o_numberaddr = (y-Y0)*20 + (x-box_left) and o_digit_sel = that box's displayed digit, and set hit stage-1 = 1.
REQ-020 SHALL register o_numberaddr = 0, o_digit_sel = 0, hit stage-1 = 0 when outside both boxes or i_video_on=0.
REQ-021 SHALL delay hit by two registers so o_pixel/o_pixel_valid for a coordinate sampled at edge E0 update at edge E2 (ROM read at E1).
REQ-022 SHALL register at E2: o_pixel = i_numberdata and o_pixel_valid = 1 if delayed hit=1 and i_numberdata != TRANSP; otherwise o_pixel = 0, o_pixel_valid = 0.
REQ-023 SHALL implement FSM states IDLE, CONV, HOLD.
REQ-024 IDLE: on i_score_load=1, latch min(i_score, 99) as remainder, clear tens counter, go CONV, o_busy=1.
REQ-025 CONV: each cycle, if remainder >= 10 subtract 10 and increment tens; else store pending tens/ones, go HOLD.
REQ-026 HOLD: on i_frame_start=1 copy pending digits to displayed digits, go IDLE, o_busy=0; o_busy stays 1 in HOLD.
REQ-027 SHALL ignore i_score_load while o_busy=1 (no queueing).
REQ-028 SHALL ignore i_frame_start in IDLE and CONV (displayed digits unchanged).
REQ-029 SHALL keep displayed digits constant between commits so a frame never mixes old and new digits.
REQ-030 SHALL not change the pixel pipeline's latency during conversion.

Reset
REQ-031 SHALL, on i_rst_n=0 at an edge, set FSM IDLE, o_busy=0, displayed and pending digits 0, o_numberaddr=0, o_digit_sel=0, o_pixel=0, o_pixel_valid=0, hit pipeline 0.
REQ-032 SHALL, on reset mid-conversion, discard the pending value; display shows 00 after reset.

Verification
REQ-033 Reset, pixel (605,23), video_on=1 -> o_numberaddr=65, o_digit_sel=0 one edge later; o_pixel_valid follows two edges after sampling.
REQ-034 Pixel (630,23) with displayed 47 -> o_numberaddr=66, o_digit_sel=7; pixel (599,23) -> addr 0, o_pixel_valid=0 at E2.
REQ-035 Load 47 -> o_busy high; CONV 4 subtract cycles + 1 store cycle; HOLD until i_frame_start; then digits 4,7, o_busy low.
REQ-036 Load 120 -> displayed 9,9 after commit; load 5 -> 0,5 after one CONV cycle.
REQ-037 Second i_score_load during CONV/HOLD -> ignored, first value displayed; ROM returns TRANSP inside box -> o_pixel_valid=0, o_pixel=0.
REQ-038 Reset asserted in HOLD with pending 47 -> digits 0,0, o_busy=0, all outputs 0 next edge.
